// File: rtl/period_meter_pkg.sv
// Shared constants for the period_meter block.
package period_meter_pkg;

    localparam int unsigned sync_depth = 2;

endpackage

// File: rtl/period_meter_synchronizer.sv
// Multi-flop synchronizer for asynchronous inputs, cleared by a synchronous reset.
`ifndef SYNCHRONIZER_V
`define SYNCHRONIZER_V
module synchronizer #(
    parameter int unsigned depth = 2,
    parameter int unsigned width = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [width-1:0] d,
    output logic [width-1:0] q
);

    logic [width-1:0] stage [depth];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < int'(depth); i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < int'(depth); i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[depth-1];

endmodule
`endif

// File: rtl/period_meter.sv
// Counts clock ticks between rising edges of signal; strobes valid with the
// captured period, or timeout when the programmable limit or saturation is hit.
`ifndef PERIOD_METER_V
`define PERIOD_METER_V
module period_meter
    import period_meter_pkg::*;
#(
    parameter int unsigned bitwidth                  = 8,
    parameter int unsigned enable_input_synchronizer = 1,
    parameter int unsigned continuous                = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic                signal,
    input  logic [bitwidth-1:0] timeout_value,
    output logic                measuring,
    output logic [bitwidth-1:0] period,
    output logic                valid,
    output logic                timeout
);

    // state   | meaning
    // IDLE    | enable low, nothing measured
    // ARM     | waiting for the edge that opens a period
    // MEASURE | counting ticks since the opening edge
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_t;

    localparam logic [bitwidth-1:0] count_max = '1;

    state_t              state_q, state_d;
    logic [bitwidth-1:0] count_q, count_d;
    logic [bitwidth-1:0] period_d;
    logic                valid_d, timeout_d;
    logic                s, s_d, rise, limit_hit;

    generate
        if (enable_input_synchronizer != 0) begin : g_sync
            synchronizer #(
                .depth (sync_depth),
                .width (1)
            ) u_sync (
                .clock (clock),
                .reset (reset),
                .d     (signal),
                .q     (s)
            );
        end else begin : g_raw
            assign s = signal;
        end
    endgenerate

    // s_d tracks s in every state, so a level already high at enable is not an edge.
    assign rise      = s & ~s_d;
    assign limit_hit = ((timeout_value != '0) && (count_q == timeout_value))
                       || (count_q == count_max);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            s_d       <= 1'b0;
            measuring <= 1'b0;
            period    <= '0;
            valid     <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            s_d       <= s;
            measuring <= (state_d == MEASURE);
            period    <= period_d;
            valid     <= valid_d;
            timeout   <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        period_d  = period;
        valid_d   = 1'b0;
        timeout_d = 1'b0;
        if (!enable) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: state_d = ARM;
                ARM: begin
                    if (rise) begin
                        state_d = MEASURE;
                        count_d = bitwidth'(1);
                    end
                end
                MEASURE: begin
                    // An edge coinciding with the limit still closes the period.
                    if (rise) begin
                        period_d = count_q;
                        valid_d  = 1'b1;
                        if (continuous != 0) begin
                            count_d = bitwidth'(1);
                        end else begin
                            state_d = ARM;
                        end
                    end else if (limit_hit) begin
                        timeout_d = 1'b1;
                        state_d   = ARM;
                    end else begin
                        count_d = count_q + bitwidth'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule
`endif

// File: tb/tb_period_meter.sv
// Directed bench for period_meter: raw/continuous 8-bit instance and
// synchronized/single-shot 4-bit instance, with an event scoreboard.
module tb_period_meter;

    typedef struct {
        bit is_to;
        int lo;
        int hi;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset;
    logic       a_en, a_sig, b_en, b_sig;
    logic [7:0] a_tv, a_period;
    logic [3:0] b_tv, b_period;
    logic       a_meas, a_valid, a_timeout;
    logic       b_meas, b_valid, b_timeout;

    int   checks   = 0;
    int   failures = 0;
    int   n;
    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;

    always #5 clock = ~clock;

    period_meter #(
        .bitwidth                  (8),
        .enable_input_synchronizer (0),
        .continuous                (1)
    ) dut_a (
        .clock         (clock),
        .reset         (reset),
        .enable        (a_en),
        .signal        (a_sig),
        .timeout_value (a_tv),
        .measuring     (a_meas),
        .period        (a_period),
        .valid         (a_valid),
        .timeout       (a_timeout)
    );

    period_meter #(
        .bitwidth                  (4),
        .enable_input_synchronizer (1),
        .continuous                (0)
    ) dut_b (
        .clock         (clock),
        .reset         (reset),
        .enable        (b_en),
        .signal        (b_sig),
        .timeout_value (b_tv),
        .measuring     (b_meas),
        .period        (b_period),
        .valid         (b_valid),
        .timeout       (b_timeout)
    );

    task automatic step(input int cycles);
        repeat (cycles) @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic ev_chk(input string tag, input logic v, input logic t,
                          input logic [31:0] p, input exp_t e);
        checks++;
        assert (v === !e.is_to && t === e.is_to && p >= 32'(e.lo) && p <= 32'(e.hi)) else begin
            failures++;
            $error("FAIL %s observed valid=%0b timeout=%0b period=%0d expected valid=%0b timeout=%0b period=%0d..%0d",
                   tag, v, t, p, !e.is_to, e.is_to, e.lo, e.hi);
        end
    endtask

    always @(negedge clock) begin
        if (a_valid === 1'b1 || a_timeout === 1'b1) begin
            checks++;
            assert (qa.size() > 0) else begin
                failures++;
                $error("FAIL a_unexpected_event observed valid=%0b timeout=%0b expected none", a_valid, a_timeout);
            end
            if (qa.size() > 0) begin
                ea = qa.pop_front();
                ev_chk("a_event", a_valid, a_timeout, 32'(a_period), ea);
            end
        end
        if (b_valid === 1'b1 || b_timeout === 1'b1) begin
            checks++;
            assert (qb.size() > 0) else begin
                failures++;
                $error("FAIL b_unexpected_event observed valid=%0b timeout=%0b expected none", b_valid, b_timeout);
            end
            if (qb.size() > 0) begin
                eb = qb.pop_front();
                ev_chk("b_event", b_valid, b_timeout, 32'(b_period), eb);
            end
        end
    end

    initial begin
        reset = 1'b1;
        a_en  = 1'b0; a_sig = 1'b0; a_tv = 8'd0;
        b_en  = 1'b0; b_sig = 1'b0; b_tv = 4'd0;
        step(3);
        chk("rst_a_measuring", 32'(a_meas), 32'd0);
        chk("rst_a_period", 32'(a_period), 32'd0);
        chk("rst_a_valid", 32'(a_valid), 32'd0);
        chk("rst_a_timeout", 32'(a_timeout), 32'd0);
        chk("rst_b_period", 32'(b_period), 32'd0);
        reset = 1'b0;
        step(1);

        // raw mode, high 2 / low 3 -> period 5 each, first edge silent
        a_en = 1'b1;
        step(1);
        for (int r = 0; r < 6; r++) begin
            if (r > 0) qa.push_back('{is_to: 1'b0, lo: 5, hi: 5});
            a_sig = 1'b1;
            step(1);
            chk("a_p5_valid", 32'(a_valid), (r > 0) ? 32'd1 : 32'd0);
            if (r > 0) chk("a_p5_period", 32'(a_period), 32'd5);
            step(1);
            a_sig = 1'b0;
            step(3);
        end

        a_en = 1'b0;
        step(1);
        chk("a_disable_measuring", 32'(a_meas), 32'd0);
        chk("a_disable_period_kept", 32'(a_period), 32'd5);

        // single edge, timeout_value 10
        a_tv = 8'd10;
        a_en = 1'b1;
        step(1);
        qa.push_back('{is_to: 1'b1, lo: 5, hi: 5});
        a_sig = 1'b1;
        step(1);
        chk("a_to_measuring", 32'(a_meas), 32'd1);
        n = -1;
        for (int i = 1; i <= 20; i++) begin
            step(1);
            if (a_timeout === 1'b1) begin
                n = i;
                break;
            end
        end
        chk("a_to_delay", 32'(n), 32'd10);
        chk("a_to_measuring_drop", 32'(a_meas), 32'd0);
        chk("a_to_period_kept", 32'(a_period), 32'd5);

        // edges 10 apart: edge beats limit
        a_sig = 1'b0;
        step(1);
        a_sig = 1'b1;
        step(1);
        a_sig = 1'b0;
        step(9);
        qa.push_back('{is_to: 1'b0, lo: 10, hi: 10});
        a_sig = 1'b1;
        step(1);
        chk("a_p10_valid", 32'(a_valid), 32'd1);
        chk("a_p10_timeout", 32'(a_timeout), 32'd0);
        chk("a_p10_period", 32'(a_period), 32'd10);

        // edges 11 apart: timeout at 10, edge at 11 only re-opens
        qa.push_back('{is_to: 1'b1, lo: 10, hi: 10});
        a_sig = 1'b0;
        step(10);
        chk("a_p11_timeout", 32'(a_timeout), 32'd1);
        a_sig = 1'b1;
        step(1);
        chk("a_p11_no_valid", 32'(a_valid), 32'd0);
        chk("a_p11_rearmed", 32'(a_meas), 32'd1);
        a_en  = 1'b0;
        a_sig = 1'b0;
        step(1);

        // reset while count = 37
        a_tv = 8'd0;
        a_en = 1'b1;
        step(1);
        a_sig = 1'b1;
        step(1);
        a_sig = 1'b0;
        step(36);
        chk("a_pre_reset_measuring", 32'(a_meas), 32'd1);
        reset = 1'b1;
        step(1);
        chk("a_midrst_measuring", 32'(a_meas), 32'd0);
        chk("a_midrst_period", 32'(a_period), 32'd0);
        chk("a_midrst_valid", 32'(a_valid), 32'd0);
        chk("a_midrst_timeout", 32'(a_timeout), 32'd0);
        reset = 1'b0;
        step(1);
        a_sig = 1'b1;
        step(1);
        chk("a_postrst_no_valid", 32'(a_valid), 32'd0);
        chk("a_postrst_measuring", 32'(a_meas), 32'd1);
        a_en  = 1'b0;
        a_sig = 1'b0;
        step(1);

        // synchronized 4-bit instance: latency and saturation at 15
        b_tv = 4'd0;
        b_en = 1'b1;
        step(1);
        qb.push_back('{is_to: 1'b1, lo: 0, hi: 0});
        b_sig = 1'b1;
        n = -1;
        for (int i = 1; i <= 8; i++) begin
            step(1);
            if (b_meas === 1'b1) begin
                n = i;
                break;
            end
        end
        chk("b_sync_latency", 32'(n), 32'd3);
        n = -1;
        for (int i = 1; i <= 30; i++) begin
            step(1);
            if (b_timeout === 1'b1) begin
                n = i;
                break;
            end
        end
        chk("b_saturation_delay", 32'(n), 32'd15);
        chk("b_sat_measuring_drop", 32'(b_meas), 32'd0);

        // single-shot: 4 edges, 4 apart -> two captures of 4
        b_sig = 1'b0;
        step(3);
        qb.push_back('{is_to: 1'b0, lo: 4, hi: 4});
        qb.push_back('{is_to: 1'b0, lo: 4, hi: 4});
        for (int r = 0; r < 4; r++) begin
            b_sig = 1'b1;
            step(2);
            b_sig = 1'b0;
            step(2);
        end
        step(4);
        chk("b_single_shot_armed", 32'(b_meas), 32'd0);
        chk("b_single_shot_period", 32'(b_period), 32'd4);

        // off-grid asynchronous input, period 70 ns = 7 clocks
        for (int r = 0; r < 4; r++) qb.push_back('{is_to: 1'b0, lo: 6, hi: 8});
        #2;
        for (int r = 0; r < 8; r++) begin
            b_sig = 1'b1;
            #35;
            b_sig = 1'b0;
            #35;
        end
        step(4);
        chk("b_async_period_range", 32'((b_period >= 4'd6) && (b_period <= 4'd8)), 32'd1);

        // input already high when enable rises
        b_en = 1'b0;
        step(1);
        b_sig = 1'b1;
        step(4);
        b_en = 1'b1;
        step(6);
        chk("b_high_at_enable_measuring", 32'(b_meas), 32'd0);
        chk("b_high_at_enable_valid", 32'(b_valid), 32'd0);
        b_sig = 1'b0;
        step(2);

        chk("a_scoreboard_drained", 32'(qa.size()), 32'd0);
        chk("b_scoreboard_drained", 32'(qb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
